// File: rtl/fsub32bit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : fsub32bit_serial
//  Description : 32-bit subtractor (a - b - bin), computed one byte per clock,
//                LSB first, with the inter-byte borrow kept in a register.
//                Reports borrow-out, signed overflow and zero at completion.
//  Revision    : 1.0  initial release
// ============================================================================
module fsub32bit_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bo,
  output logic        ovf,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  idx;
  logic        borrow;
  logic [31:0] a_q;
  logic [31:0] b_q;

  // Byte slice of the current step and the word as it will look after it.
  logic [4:0]  bit_base;
  logic [8:0]  slice_sub;
  logic [31:0] diff_next;

  // Subtract the selected byte pair with the running borrow; bit 8 is borrow out.
  always_comb begin
    bit_base  = {idx, 3'b000};
    slice_sub = {1'b0, a_q[bit_base +: 8]} - {1'b0, b_q[bit_base +: 8]} - {8'd0, borrow};
    diff_next = diff;
    diff_next[bit_base +: 8] = slice_sub[7:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs; start is only honoured outside CALC.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (idx == 2'd3) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, then one byte per CALC edge.
  // Flags are only touched on the final byte so they hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= 2'd0;
      borrow <= 1'b0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      diff   <= 32'd0;
      bo     <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            idx    <= 2'd0;
          end
        end
        CALC: begin
          diff   <= diff_next;
          borrow <= slice_sub[8];
          idx    <= idx + 2'd1;
          if (idx == 2'd3) begin
            bo   <= slice_sub[8];
            ovf  <= (a_q[31] != b_q[31]) && (diff_next[31] != a_q[31]);
            zero <= (diff_next == 32'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsub32bit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsub32bit_serial
//  Description : Self-checking bench for fsub32bit_serial: directed vector
//                table, randomized operands against an arithmetic model, and
//                hand-written sequences for restart, reset and back-to-back.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fsub32bit_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bo;
  logic        ovf;
  logic        zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bo;
    logic        ovf;
    logic        zero;
  } vec_t;

  always #5 clk = ~clk;

  fsub32bit_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bo    (bo),
    .ovf   (ovf),
    .zero  (zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: whole-word arithmetic, 33-bit for the borrow.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                       output logic [31:0] md, output logic mbo, output logic movf,
                       output logic mzero);
    logic [32:0] rhs;
    md    = ma - mb - {31'd0, mbin};
    rhs   = {1'b0, mb} + {32'd0, mbin};
    mbo   = ({1'b0, ma} < rhs);
    movf  = (ma[31] != mb[31]) && (md[31] != ma[31]);
    mzero = (md == 32'd0);
  endtask

  // One full operation; operands are scrambled right after acceptance.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tbin, input logic [31:0] ed, input logic ebo,
                        input logic eovf, input logic ezero);
    int n;
    int nbusy;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    n = 0; nbusy = 0;
    while (!done && n < 12) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, 4);
    chk({tag, ".busy_cycles"}, nbusy, 4);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bo"}, bo, ebo);
    chk({tag, ".ovf"}, ovf, eovf);
    chk({tag, ".zero"}, zero, ezero);
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] md;
    logic        mbo, movf, mzero;
    logic [31:0] cap;
    int          n;
    int          ndone;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.diff", diff, 0);
    chk("reset.bo", bo, 0);
    chk("reset.ovf", ovf, 0);
    chk("reset.zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, then confirm single-cycle done and held results.
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].diff, vecs[i].bo, vecs[i].ovf, vecs[i].zero);
      @(negedge clk);
      chk($sformatf("vec%0d.done_once", i), done, 0);
      chk($sformatf("vec%0d.idle_busy", i), busy, 0);
      chk($sformatf("vec%0d.hold_diff", i), diff, vecs[i].diff);
    end

    // Randomized operands against the model; every fourth has a == b.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic        rbin;
      ra   = $urandom;
      rb   = (i % 4 == 0) ? ra : $urandom;
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, md, mbo, movf, mzero);
      run_op($sformatf("rnd%0d", i), ra, rb, rbin, md, mbo, movf, mzero);
    end

    // Start re-pulsed during CALC with other operands is ignored.
    @(negedge clk);
    a = 32'h5; b = 32'h3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'h1234; b = 32'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap = '0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin ndone++; cap = diff; end
      @(negedge clk);
    end
    chk("restart.done_pulses", ndone, 1);
    chk("restart.diff", cap, 32'h2);

    // Reset mid-CALC at index 2 abandons the operation.
    @(negedge clk);
    a = 32'hAAAA_5555; b = 32'h0000_1111; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0; start = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.diff", diff, 0);
    chk("midrst.bo", bo, 0);
    chk("midrst.ovf", ovf, 0);
    chk("midrst.zero", zero, 0);
    ndone = 0; n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) n++;
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) n++;
    end
    chk("midrst.no_done", ndone, 0);
    chk("midrst.no_busy", n, 0);
    run_op("post_rst", 32'h10, 32'h01, 1'b0, 32'h0F, 1'b0, 1'b0, 1'b0);

    // Start held across DONE: second operation starts with no idle cycle.
    @(negedge clk);
    a = 32'h5; b = 32'h3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.first_done", done, 1);
    chk("b2b.first_diff", diff, 32'h2);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.no_idle_busy", busy, 1);
    chk("b2b.no_idle_done", done, 0);
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.latency", n, 4);
    chk("b2b.diff", diff, 32'h0);
    chk("b2b.zero", zero, 1);
    chk("b2b.bo", bo, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
